// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } hazard_state_e;

  // Canonical bubble instruction (addi x0, x0, 0) injected by the decode stage.
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Hard-wired zero register; never a source of a data hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the residency down-counter.
  localparam int unsigned SEQ_CNT_W = 4;

  // Counter load value for a sequence of 'cyc' total cycles; the first cycle
  // is spent in RUN, so the FSM only covers the remaining cyc-1 cycles.
  function automatic logic [SEQ_CNT_W-1:0] reload_val(input int unsigned cyc);
    return SEQ_CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the execute-stage destination and the
// decode-stage sources. Purely combinational so it can be reused for
// forwarding-path checks.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] dec_rs1_addr_i,
  input  logic [4:0] dec_rs2_addr_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_wren_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);

  logic rd_match;

  // A load writing a real register that decode is about to read must bubble.
  always_comb begin
    rd_match   = (ex_rd_addr_i == dec_rs1_addr_i) || (ex_rd_addr_i == dec_rs2_addr_i);
    load_use_o = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != REG_X0) && rd_match;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: generates stall, flush and freeze controls for
// the fetch/decode/execute registers. Priority each cycle is
// freeze (LSU wait) > redirect > load-use.
// Optional feature macro: HAZARD_PERF_EN (saturating stall/flush counters).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned FLUSH_CYC      = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             i_hazard_clk,
  input  logic             i_hazard_reset,
  input  logic [4:0]       i_hazard_dec_rs1_addr,
  input  logic [4:0]       i_hazard_dec_rs2_addr,
  input  logic [4:0]       i_hazard_ex_rd_addr,
  input  logic             i_hazard_ex_rd_wren,
  input  logic             i_hazard_ex_is_load,
  input  logic             i_hazard_redirect,
  input  logic             i_hazard_lsu_busy,
  output logic             o_hazard_stall_fetch,
  output logic             o_hazard_stall_decode,
  output logic             o_hazard_flush_decode,
  output logic             o_hazard_flush_execute,
  output logic             o_hazard_freeze,
  output logic             o_hazard_busy,
  output logic [CNT_W-1:0] o_hazard_stall_cnt,
  output logic [CNT_W-1:0] o_hazard_flush_cnt
);

  localparam logic [SEQ_CNT_W-1:0] LS_RELOAD = reload_val(LOAD_STALL_CYC);
  localparam logic [SEQ_CNT_W-1:0] FL_RELOAD = reload_val(FLUSH_CYC);
  localparam logic [SEQ_CNT_W-1:0] CNT_ONE   = SEQ_CNT_W'(1);

  hazard_state_e        state_q, state_d;
  logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic stall_c;
  logic flush_c;
  logic freeze_c;
  logic redirect_accept;

  hazard_detect u_detect (
    .dec_rs1_addr_i (i_hazard_dec_rs1_addr),
    .dec_rs2_addr_i (i_hazard_dec_rs2_addr),
    .ex_rd_addr_i   (i_hazard_ex_rd_addr),
    .ex_rd_wren_i   (i_hazard_ex_rd_wren),
    .ex_is_load_i   (i_hazard_ex_is_load),
    .load_use_o     (load_use)
  );

  // State and residency counter; reset drops straight back to RUN.
  always_ff @(posedge i_hazard_clk or posedge i_hazard_reset) begin
    if (i_hazard_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control decode; controls are forced low during reset.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall_c         = 1'b0;
    flush_c         = 1'b0;
    freeze_c        = 1'b0;
    redirect_accept = 1'b0;
    if (i_hazard_reset) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (i_hazard_lsu_busy) begin
      // LSU wait: hold everything, pending hazards are re-evaluated later.
      freeze_c = 1'b1;
    end else if (i_hazard_redirect) begin
      // A redirect flushes from any state and (re)starts the flush sequence.
      flush_c         = 1'b1;
      redirect_accept = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_d = FLUSH;
        cnt_d   = FL_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            stall_c = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = LDSTALL;
              cnt_d   = LS_RELOAD;
            end
          end
        end
        LDSTALL: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = RUN;
        end
        FLUSH: begin
          flush_c = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_hazard_stall_fetch   = stall_c;
  assign o_hazard_stall_decode  = stall_c;
  assign o_hazard_flush_decode  = flush_c;
  assign o_hazard_flush_execute = flush_c;
  assign o_hazard_freeze        = freeze_c;
  assign o_hazard_busy          = !i_hazard_reset && (state_q != RUN);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counts: stall bubbles per cycle, redirects per accept.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && !(&stall_cnt_q))         stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_accept && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Performance counter registers.
  always_ff @(posedge i_hazard_clk or posedge i_hazard_reset) begin
    if (i_hazard_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_hazard_stall_cnt = stall_cnt_q;
  assign o_hazard_flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf        = redirect_accept;
  assign o_hazard_stall_cnt = '0;
  assign o_hazard_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: four parameterisations share one
// stimulus stream; a per-cycle expectation is queued by the driver and
// popped/compared by an independent monitor on the falling edge.
module tb_hazard_ctrl;

  localparam int N = 4;
  localparam int LS  [N] = '{1, 3, 1, 4};
  localparam int FCY [N] = '{1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       wren, ld, redir, lsu;

  logic [N-1:0] sf, sd, fd, fe, fz, bz;
  logic [31:0]  scnt [N];
  logic [31:0]  fcnt [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    hazard_ctrl #(
      .LOAD_STALL_CYC (LS[gi]),
      .FLUSH_CYC      (FCY[gi]),
      .CNT_W          (32)
    ) u_dut (
      .i_hazard_clk           (clk),
      .i_hazard_reset         (rst),
      .i_hazard_dec_rs1_addr  (rs1),
      .i_hazard_dec_rs2_addr  (rs2),
      .i_hazard_ex_rd_addr    (rd),
      .i_hazard_ex_rd_wren    (wren),
      .i_hazard_ex_is_load    (ld),
      .i_hazard_redirect      (redir),
      .i_hazard_lsu_busy      (lsu),
      .o_hazard_stall_fetch   (sf[gi]),
      .o_hazard_stall_decode  (sd[gi]),
      .o_hazard_flush_decode  (fd[gi]),
      .o_hazard_flush_execute (fe[gi]),
      .o_hazard_freeze        (fz[gi]),
      .o_hazard_busy          (bz[gi]),
      .o_hazard_stall_cnt     (scnt[gi]),
      .o_hazard_flush_cnt     (fcnt[gi])
    );
  end

  // Expected response for one cycle, all instances.
  // ctl bits: {busy, freeze, flush_ex, flush_dec, stall_dec, stall_fetch}
  typedef struct {
    int          cyc;
    logic [5:0]  ctl [N];
    logic [31:0] sc  [N];
    logic [31:0] fc  [N];
  } exp_t;

  exp_t exp_q [$];

  int tests  = 0;
  int fails  = 0;
  int cyc_no = 0;

  // Reference model: remaining stall/flush cycles as plain integers.
  int          stall_left [N];
  int          flush_left [N];
  logic [31:0] m_sc [N];
  logic [31:0] m_fc [N];

  task automatic model_step();
    exp_t e;
    logic lu;
    lu = ld && wren && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    e.cyc = cyc_no;
    for (int i = 0; i < N; i++) begin
      e.ctl[i] = 6'b0;
      if (rst) begin
        stall_left[i] = 0;
        flush_left[i] = 0;
        m_sc[i] = 32'd0;
        m_fc[i] = 32'd0;
      end
`ifdef HAZARD_PERF_EN
      e.sc[i] = m_sc[i];
      e.fc[i] = m_fc[i];
`else
      e.sc[i] = 32'd0;
      e.fc[i] = 32'd0;
`endif
      if (!rst) begin
        e.ctl[i][5] = (stall_left[i] > 0) || (flush_left[i] > 0);
        if (lsu) begin
          e.ctl[i][4] = 1'b1;
        end else if (redir) begin
          e.ctl[i][3:2] = 2'b11;
          if (m_fc[i] != 32'hFFFF_FFFF) m_fc[i] = m_fc[i] + 1;
          flush_left[i] = FCY[i] - 1;
          stall_left[i] = 0;
        end else if (flush_left[i] > 0) begin
          e.ctl[i][3:2] = 2'b11;
          flush_left[i]--;
        end else if (stall_left[i] > 0 || lu) begin
          e.ctl[i][1:0] = 2'b11;
          if (m_sc[i] != 32'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
          if (stall_left[i] > 0) stall_left[i]--;
          else                   stall_left[i] = LS[i] - 1;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Apply one cycle of inputs just after the rising edge and queue the answer.
  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic w, input logic l,
                       input logic rdir, input logic lb);
    @(posedge clk);
    #1;
    rst = r; rs1 = a1; rs2 = a2; rd = d; wren = w; ld = l; redir = rdir; lsu = lb;
    cyc_no++;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++) begin
          act = {bz[i], fz[i], fe[i], fd[i], sd[i], sf[i]};
          tests++;
          if (act !== e.ctl[i]) begin
            fails++;
            $display("FAIL ctl dut%0d cyc %0d: got %b expected %b", i, e.cyc, act, e.ctl[i]);
          end
          tests++;
          if (scnt[i] !== e.sc[i]) begin
            fails++;
            $display("FAIL stall_cnt dut%0d cyc %0d: got %0d expected %0d", i, e.cyc, scnt[i], e.sc[i]);
          end
          tests++;
          if (fcnt[i] !== e.fc[i]) begin
            fails++;
            $display("FAIL flush_cnt dut%0d cyc %0d: got %0d expected %0d", i, e.cyc, fcnt[i], e.fc[i]);
          end
        end
        $display("[TB] cyc %0d rst=%b lsu=%b redir=%b ld=%b rd=%0d rs=%0d/%0d ctl %b %b %b %b",
                 e.cyc, rst, lsu, redir, ld, rd, rs1, rs2,
                 {bz[0], fz[0], fe[0], fd[0], sd[0], sf[0]},
                 {bz[1], fz[1], fe[1], fd[1], sd[1], sf[1]},
                 {bz[2], fz[2], fe[2], fd[2], sd[2], sf[2]},
                 {bz[3], fz[3], fe[3], fd[3], sd[3], sf[3]});
      end
    end
  end

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; wren = 1'b0; ld = 1'b0; redir = 1'b0; lsu = 1'b0;
    for (int i = 0; i < N; i++) begin
      stall_left[i] = 0; flush_left[i] = 0; m_sc[i] = '0; m_fc[i] = '0;
    end

    // Reset held for two cycles.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Basic load-use on rs1, then on rs2.
    drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    drive(1'b0, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);

    // No hazard: rd = x0, or not a load, or not writing rd.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Load-use followed by a redirect on the second stall cycle.
    drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // Redirect, then a second redirect while still flushing.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // LSU wait overlapping a load-use: freeze first, stall afterwards.
    for (int k = 0; k < 3; k++) drive(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Reset in the middle of a long load-use stall.
    drive(1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Randomised traffic with a small register range to provoke hazards.
    for (int k = 0; k < 500; k++) begin
      drive(1'($urandom_range(0, 99) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
    end
    idle(2);

    // Let the monitor drain the queue.
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
